// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM pulse sequencer and its downstream single-shot generator.
package pwm_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_FIRE = 3'd1,
      S_WAIT = 3'd2,
      S_GAP  = 3'd3,
      S_DONE = 3'd4
   } seq_state_t;

   localparam int PW_W_DEF = 12;

   // Downstream end + idle states after its high phase; both blocks must agree.
   localparam int SEQ_TAIL = 2;

endpackage

// File: rtl/pwm_seq_timer.sv
// Loadable down-counter with a terminal-count flag, shared by the WAIT and GAP phases.
module pwm_seq_timer #(
   parameter int W = 13
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] load_val,
   output logic         tc
);

   logic [W-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   // A phase loaded with L lasts L cycles: the last one is where count == 1.
   assign tc = (count == W'(1));

endmodule

// File: rtl/pwm_pulse_seq.sv
// Trigger-train sequencer for the single-shot PWM generator.
// Optional build macro PWM_SEQ_RAMP_EN adds a saturating per-pulse width ramp.
module pwm_pulse_seq
   import pwm_pkg::*;
#(
   parameter int CNT_W = 8,
   parameter int PW_W  = PW_W_DEF,
   parameter int GAP_W = 12,
   parameter int TAIL  = SEQ_TAIL
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic [PW_W-1:0]  i_pulse_width,
   input  logic [CNT_W-1:0] i_num_pulses,
   input  logic [GAP_W-1:0] i_gap,
   input  logic [PW_W-1:0]  i_step,
   output logic             o_pwm_tri,
   output logic [PW_W-1:0]  o_pulse_width,
   output logic [CNT_W-1:0] o_pulse_idx,
   output logic             o_busy,
   output logic             o_done
);

   localparam int TMR_W = (PW_W + 1 > GAP_W) ? PW_W + 1 : GAP_W;

   seq_state_t       state;
   logic [CNT_W-1:0] num_q;
   logic [GAP_W-1:0] gap_q;
   logic [PW_W-1:0]  width_nxt;
   logic [CNT_W-1:0] idx_inc;
   logic             last_pulse;
   logic             gap_nz;
   logic             tmr_load;
   logic             tmr_en;
   logic             tmr_tc;
   logic [TMR_W-1:0] tmr_val;

   assign idx_inc    = o_pulse_idx + 1'b1;
   assign last_pulse = (idx_inc == num_q);
   assign gap_nz     = (gap_q != '0);

`ifdef PWM_SEQ_RAMP_EN
   logic [PW_W-1:0] step_q;
   logic [PW_W:0]   ramp_sum;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         step_q <= '0;
      end else if ((state == S_IDLE) && i_start && !i_abort) begin
         step_q <= i_step;
      end
   end

   // The first pulse keeps the programmed width; later pulses step up and clamp.
   always_comb begin
      ramp_sum  = {1'b0, o_pulse_width} + {1'b0, step_q};
      width_nxt = o_pulse_width;
      if (o_pulse_idx != '0) begin
         width_nxt = ramp_sum[PW_W] ? '1 : ramp_sum[PW_W-1:0];
      end
   end
`else
   logic unused_step;
   assign unused_step = ^i_step;
   assign width_nxt   = o_pulse_width;
`endif

   always_comb begin
      tmr_load = 1'b0;
      tmr_en   = 1'b0;
      tmr_val  = TMR_W'(gap_q);
      if (!i_abort) begin
         case (state)
            S_FIRE: begin
               tmr_load = 1'b1;
               tmr_val  = TMR_W'(width_nxt) + TMR_W'(TAIL);
            end
            S_WAIT: begin
               if (tmr_tc && gap_nz) tmr_load = 1'b1;
               else                  tmr_en   = 1'b1;
            end
            S_GAP:   tmr_en = 1'b1;
            default: tmr_en = 1'b0;
         endcase
      end
   end

   pwm_seq_timer #(.W(TMR_W)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .en       (tmr_en),
      .load_val (tmr_val),
      .tc       (tmr_tc)
   );

   // Strobes and busy follow the state of the previous cycle; abort masks them at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_IDLE;
         num_q         <= '0;
         gap_q         <= '0;
         o_pwm_tri     <= 1'b0;
         o_pulse_width <= '0;
         o_pulse_idx   <= '0;
         o_busy        <= 1'b0;
         o_done        <= 1'b0;
      end else begin
         o_pwm_tri <= (state == S_FIRE) && !i_abort;
         o_busy    <= (state inside {S_FIRE, S_WAIT, S_GAP}) && !i_abort;
         o_done    <= (state == S_DONE) && !i_abort;
         if ((state != S_IDLE) && i_abort) begin
            state <= S_IDLE;
         end else begin
            case (state)
               S_IDLE: begin
                  if (i_start && !i_abort) begin
                     num_q         <= i_num_pulses;
                     gap_q         <= i_gap;
                     o_pulse_width <= i_pulse_width;
                     o_pulse_idx   <= '0;
                     state         <= (i_num_pulses == '0) ? S_DONE : S_FIRE;
                  end
               end
               S_FIRE: begin
                  o_pulse_width <= width_nxt;
                  state         <= S_WAIT;
               end
               S_WAIT: begin
                  if (tmr_tc) begin
                     if (gap_nz) begin
                        state <= S_GAP;
                     end else if (last_pulse) begin
                        state <= S_DONE;
                     end else begin
                        o_pulse_idx <= idx_inc;
                        state       <= S_FIRE;
                     end
                  end
               end
               S_GAP: begin
                  if (tmr_tc) begin
                     if (last_pulse) begin
                        state <= S_DONE;
                     end else begin
                        o_pulse_idx <= idx_inc;
                        state       <= S_FIRE;
                     end
                  end
               end
               S_DONE:  state <= S_IDLE;
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pwm_pulse_seq.sv
// Bench for pwm_pulse_seq: table of trains plus abort, reset and ramp sequences.
module tb_pwm_pulse_seq;
   import pwm_pkg::*;

   localparam int CNT_W = 8;
   localparam int PW_W  = 12;
   localparam int GAP_W = 12;
   localparam int EW    = 41;

   typedef struct {
      int w;
      int n;
      int g;
      int period;
      int done;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             i_start = 1'b0;
   logic             i_abort = 1'b0;
   logic [PW_W-1:0]  i_pulse_width = '0;
   logic [CNT_W-1:0] i_num_pulses = '0;
   logic [GAP_W-1:0] i_gap = '0;
   logic [PW_W-1:0]  i_step = '0;
   logic             o_pwm_tri;
   logic [PW_W-1:0]  o_pulse_width;
   logic [CNT_W-1:0] o_pulse_idx;
   logic             o_busy;
   logic             o_done;

   pwm_pulse_seq #(.CNT_W(CNT_W), .PW_W(PW_W), .GAP_W(GAP_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .i_start       (i_start),
      .i_abort       (i_abort),
      .i_pulse_width (i_pulse_width),
      .i_num_pulses  (i_num_pulses),
      .i_gap         (i_gap),
      .i_step        (i_step),
      .o_pwm_tri     (o_pwm_tri),
      .o_pulse_width (o_pulse_width),
      .o_pulse_idx   (o_pulse_idx),
      .o_busy        (o_busy),
      .o_done        (o_done)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // scoreboard state
   logic [EW-1:0] exp_q[$];
   int checks   = 0;
   int passes   = 0;
   int busy_lo  = 1;
   int busy_hi  = 0;
   int busy_bad = 0;
   int ds_cnt   = 0;
   int ds_err   = 0;
   int ds_high  = 0;
   vec_t tbl[11];

   function automatic logic [EW-1:0] make_ev(input bit d, input int c, input int idx, input int w);
      return {d, 20'(c), 8'(idx), 12'(w)};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
   endtask

   // monitor: busy window, downstream generator model, trigger/done scoreboard
   always @(negedge clk) begin
      logic [EW-1:0] act;
      if (rst) begin
         ds_cnt = 0;
      end else begin
         if (o_busy !== ((cyc >= busy_lo) && (cyc <= busy_hi))) busy_bad++;
         if (o_pwm_tri) begin
            if (ds_cnt != 0) ds_err++;
            ds_cnt = int'(o_pulse_width) + SEQ_TAIL;
         end else if (ds_cnt > 0) begin
            if (ds_cnt > SEQ_TAIL) ds_high++;
            ds_cnt--;
         end
         if (o_pwm_tri || o_done) begin
            act = make_ev(o_done, cyc, o_done ? 0 : int'(o_pulse_idx), o_done ? 0 : int'(o_pulse_width));
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_event: got 0x%0h required none", act);
            end else begin
               check("event", act, exp_q.pop_front());
            end
         end
      end
   end

   task automatic wait_drain(input string name, input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      check(name, exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic drive_start(input int w, input int n, input int g, input int st, output int t0);
      @(posedge clk); #1;
      i_pulse_width = 12'(w);
      i_num_pulses  = 8'(n);
      i_gap         = 12'(g);
      i_step        = 12'(st);
      i_start       = 1'b1;
      t0            = cyc;
      ds_err        = 0;
      ds_high       = 0;
      busy_bad      = 0;
   endtask

   task automatic run_train(input vec_t v, input bit garbage);
      int t0;
      drive_start(v.w, v.n, v.g, 0, t0);
      for (int k = 0; k < v.n; k++) exp_q.push_back(make_ev(1'b0, t0 + 2 + k * v.period, k, v.w));
      exp_q.push_back(make_ev(1'b1, t0 + v.done, 0, 0));
      busy_lo = t0 + 2;
      busy_hi = t0 + v.done - 1;
      @(posedge clk); #1;
      i_start = 1'b0;
      if (garbage && v.n > 0) begin
         @(posedge clk); #1;
         i_pulse_width = 12'($urandom_range(0, 4095));
         i_num_pulses  = 8'($urandom_range(0, 255));
         i_gap         = 12'($urandom_range(0, 4095));
         i_start       = 1'b1;
         @(posedge clk); #1;
         i_start = 1'b0;
      end
      wait_drain("train_end", v.done + 20);
      @(negedge clk);
      check("busy_window", busy_bad, 0);
      check("no_retrigger", ds_err, 0);
      check("high_cycles", ds_high, v.n * v.w);
   endtask

   initial begin
      int t0;
      int t1;
      tbl[0] = '{5, 3, 0, 8, 26};
      tbl[1] = '{4, 2, 3, 10, 22};
      tbl[2] = '{0, 0, 0, 0, 2};
      tbl[3] = '{0, 2, 1, 4, 10};
      tbl[4] = '{4095, 1, 0, 4098, 4100};
      tbl[5] = '{1, 5, 2, 6, 32};
      tbl[6] = '{7, 1, 12, 22, 24};
      tbl[7] = '{3, 255, 0, 6, 1532};
      for (int i = 8; i < 11; i++) begin
         tbl[i].w      = $urandom_range(0, 40);
         tbl[i].n      = $urandom_range(1, 6);
         tbl[i].g      = $urandom_range(0, 5);
         tbl[i].period = tbl[i].w + 3 + tbl[i].g;
         tbl[i].done   = 2 + tbl[i].n * tbl[i].period;
      end

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tri", o_pwm_tri, 0);
      check("rst_busy", o_busy, 0);
      check("rst_done", o_done, 0);
      check("rst_idx", o_pulse_idx, 0);
      check("rst_width", o_pulse_width, 0);
      #1 rst = 1'b0;

      for (int i = 0; i < 11; i++) run_train(tbl[i], 1'b1);

      // async reset in the middle of a train
      drive_start(6, 3, 0, 0, t0);
      exp_q.push_back(make_ev(1'b0, t0 + 2, 0, 6));
      exp_q.push_back(make_ev(1'b0, t0 + 11, 1, 6));
      busy_lo = t0 + 2;
      busy_hi = t0 + 100;
      @(posedge clk); #1;
      i_start = 1'b0;
      repeat (11) @(posedge clk);
      #2;
      busy_hi = t0 + 11;
      rst = 1'b1;
      #1;
      check("async_rst_outputs", {o_pwm_tri, o_busy, o_done, o_pulse_idx, o_pulse_width}, 0);
      check("async_rst_queue", exp_q.size(), 0);
      exp_q.delete();
      @(negedge clk);
      #1 rst = 1'b0;
      run_train('{3, 2, 0, 6, 14}, 1'b0);

      // start and abort together in IDLE: start ignored
      @(posedge clk); #1;
      i_pulse_width = 12'd9;
      i_num_pulses  = 8'd1;
      i_gap         = 12'd0;
      i_start       = 1'b1;
      i_abort       = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      i_abort = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("start_abort_busy", o_busy, 0);
      check("start_abort_width", o_pulse_width, 3);

      // abort during the second WAIT, then immediate restart
      drive_start(5, 4, 0, 0, t0);
      exp_q.push_back(make_ev(1'b0, t0 + 2, 0, 5));
      exp_q.push_back(make_ev(1'b0, t0 + 10, 1, 5));
      busy_lo = t0 + 2;
      busy_hi = t0 + 13;
      @(posedge clk); #1;
      i_start = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      i_abort = 1'b1;
      @(posedge clk); #1;
      i_abort = 1'b0;
      check("abort_busy", o_busy, 0);
      check("abort_tri", o_pwm_tri, 0);
      check("abort_done", o_done, 0);
      check("abort_width_hold", o_pulse_width, 5);
      check("abort_queue", exp_q.size(), 0);
      i_pulse_width = 12'd2;
      i_num_pulses  = 8'd1;
      i_start       = 1'b1;
      t1            = cyc;
      exp_q.push_back(make_ev(1'b0, t1 + 2, 0, 2));
      exp_q.push_back(make_ev(1'b1, t1 + 7, 0, 0));
      busy_lo  = t1 + 2;
      busy_hi  = t1 + 6;
      busy_bad = 0;
      @(posedge clk); #1;
      i_start = 1'b0;
      wait_drain("restart_end", 40);
      @(negedge clk);
      check("restart_busy", busy_bad, 0);

`ifdef PWM_SEQ_RAMP_EN
      // ramp with saturation; a second start while busy is ignored
      drive_start(4090, 3, 0, 4, t0);
      exp_q.push_back(make_ev(1'b0, t0 + 2, 0, 4090));
      exp_q.push_back(make_ev(1'b0, t0 + 4095, 1, 4094));
      exp_q.push_back(make_ev(1'b0, t0 + 8192, 2, 4095));
      exp_q.push_back(make_ev(1'b1, t0 + 12290, 0, 0));
      busy_lo = t0 + 2;
      busy_hi = t0 + 12289;
      @(posedge clk); #1;
      i_start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      i_pulse_width = 12'd10;
      i_num_pulses  = 8'd1;
      i_step        = 12'd100;
      i_start       = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      wait_drain("ramp_end", 12400);
      @(negedge clk);
      check("ramp_busy", busy_bad, 0);
      check("ramp_no_retrigger", ds_err, 0);
`endif

      repeat (5) @(posedge clk);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
